sync_control_fsm: RTL and testbench

SYNC_CONTROL_FSM -- requirements
Module: sync_control_fsm

---
 rtl/sync_control_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_sync_control_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_control_fsm.sv
// rtl/sync_control_fsm.sv - multi-cycle MIPS control FSM with memory watchdog and optional LL/SC link tracking
//
// Purpose: sequences each instruction through FETCH, DECODE, EXEC, MEM, WB (and HALTED).
// Moore outputs are decoded from the state register and the latched instruction (ir).
// Optional feature macro: LLSC_EN. When it is defined, LL/SC use a link register.
// When it is undefined, LL behaves as LW, and SC behaves as SW followed by a WB that writes 1.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   instr, ihit          imem read data / imem done
//   dhit                 dmem done
//   zero                 ALU zero flag, resolves BEQ/BNE in EXEC
//   daddr, snoop_inv     dmem address / remote write to the link address (LLSC_EN only)
//   ir                   latched instruction
//   iREN, dREN, dWEN     memory requests
//   PCen, pc_sel         PC update strobe and source (00 +4, 01 branch, 10 jump, 11 jr)
//   RegWr, RegDst        register write strobe / rd-vs-rt destination (rd also for JAL)
//   MemtoReg, lui, jal_s writeback source selects
//   ALUSrc, ExtOp        immediate operand select / sign-extend
//   ALUctr               ALU operation, driven in EXEC
//   halt                 processor halted
//   mem_timeout          sticky watchdog flag
//   state                current FSM state
//   sc_result            value SC writes back in WB (1 success, 0 fail)
module sync_control_fsm #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] instr,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              zero,
    input  logic [WORD_W-1:0] daddr,
    input  logic              snoop_inv,
    output logic [31:0]       ir,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              PCen,
    output logic              RegWr,
    output logic              ALUSrc,
    output logic              ExtOp,
    output logic              MemtoReg,
    output logic              lui,
    output logic              jal_s,
    output logic              halt,
    output logic              mem_timeout,
    output logic              RegDst,
    output logic [1:0]        pc_sel,
    output logic [3:0]        ALUctr,
    output logic [2:0]        state,
    output logic              sc_result
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d, OP_XORI = 6'h0e, OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b, OP_LL   = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38, OP_HALT = 6'h3f;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;

    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        sc_ok;
    logic        sc_res;

    // Instruction decode of the latched word
    logic [3:0] dec_alu;
    logic dec_src, dec_ext, dec_rtype, dec_undef, dec_halt, dec_lui;
    logic dec_rd, dec_wr, dec_ll, dec_sc, dec_sw;
    logic dec_beq, dec_bne, dec_j, dec_jal, dec_jr;

    always_comb begin
        dec_alu   = ALU_ADD;
        dec_src   = 1'b0;
        dec_ext   = 1'b0;
        dec_rtype = 1'b0;
        dec_undef = 1'b0;
        dec_halt  = 1'b0;
        dec_lui   = 1'b0;
        dec_rd    = 1'b0;
        dec_wr    = 1'b0;
        dec_ll    = 1'b0;
        dec_sc    = 1'b0;
        dec_sw    = 1'b0;
        dec_beq   = 1'b0;
        dec_bne   = 1'b0;
        dec_j     = 1'b0;
        dec_jal   = 1'b0;
        dec_jr    = 1'b0;
        case (ir_q[31:26])
            OP_RTYPE: begin
                dec_rtype = 1'b1;
                case (ir_q[5:0])
                    F_SLL:         dec_alu = ALU_SLL;
                    F_SRL:         dec_alu = ALU_SRL;
                    F_JR:          dec_jr  = 1'b1;
                    F_ADD, F_ADDU: dec_alu = ALU_ADD;
                    F_SUB, F_SUBU: dec_alu = ALU_SUB;
                    F_AND:         dec_alu = ALU_AND;
                    F_OR:          dec_alu = ALU_OR;
                    F_XOR:         dec_alu = ALU_XOR;
                    F_NOR:         dec_alu = ALU_NOR;
                    F_SLT:         dec_alu = ALU_SLT;
                    F_SLTU:        dec_alu = ALU_SLTU;
                    default:       dec_undef = 1'b1;
                endcase
            end
            OP_J:     dec_j   = 1'b1;
            OP_JAL:   dec_jal = 1'b1;
            OP_BEQ:   begin dec_beq = 1'b1; dec_alu = ALU_SUB; dec_ext = 1'b1; end
            OP_BNE:   begin dec_bne = 1'b1; dec_alu = ALU_SUB; dec_ext = 1'b1; end
            OP_ADDIU: begin dec_src = 1'b1; dec_ext = 1'b1; end
            OP_SLTI:  begin dec_src = 1'b1; dec_ext = 1'b1; dec_alu = ALU_SLT; end
            OP_SLTIU: begin dec_src = 1'b1; dec_ext = 1'b1; dec_alu = ALU_SLTU; end
            OP_ANDI:  begin dec_src = 1'b1; dec_alu = ALU_AND; end
            OP_ORI:   begin dec_src = 1'b1; dec_alu = ALU_OR; end
            OP_XORI:  begin dec_src = 1'b1; dec_alu = ALU_XOR; end
            OP_LUI:   begin dec_src = 1'b1; dec_lui = 1'b1; end
            OP_LW:    begin dec_src = 1'b1; dec_ext = 1'b1; dec_rd = 1'b1; end
            OP_LL:    begin dec_src = 1'b1; dec_ext = 1'b1; dec_rd = 1'b1; dec_ll = 1'b1; end
            OP_SW:    begin dec_src = 1'b1; dec_ext = 1'b1; dec_wr = 1'b1; dec_sw = 1'b1; end
            OP_SC:    begin dec_src = 1'b1; dec_ext = 1'b1; dec_wr = 1'b1; dec_sc = 1'b1; end
            OP_HALT:  dec_halt = 1'b1;
            default:  dec_undef = 1'b1;
        endcase
    end

`ifdef LLSC_EN
    logic              link_valid_q, link_valid_d;
    logic [WORD_W-1:0] link_addr_q, link_addr_d;
    logic              sc_res_q, sc_res_d;

    // A snoop in the same cycle as dhit kills the SC: the write is never issued.
    assign sc_ok  = link_valid_q && (daddr == link_addr_q) && !snoop_inv;
    assign sc_res = sc_res_q;

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        sc_res_d     = sc_res_q;
        if (state_q == MEM) begin
            if (dec_ll && dhit) begin
                link_valid_d = 1'b1;
                link_addr_d  = daddr;
            end
            if (dec_sw && dhit && (daddr == link_addr_q)) begin
                link_valid_d = 1'b0;
            end
            if (dec_sc && (dhit || !sc_ok)) begin
                link_valid_d = 1'b0;
                sc_res_d     = sc_ok;
            end
        end
        if (snoop_inv) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            sc_res_q     <= 1'b0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            sc_res_q     <= sc_res_d;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{daddr, snoop_inv};
    assign sc_ok         = 1'b1;
    assign sc_res        = 1'b1;
`endif

    // Next state and Moore outputs
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        iREN      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        PCen      = 1'b0;
        pc_sel    = 2'b00;
        RegWr     = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        lui       = 1'b0;
        jal_s     = 1'b0;
        halt      = 1'b0;
        ALUctr    = ALU_SLL;
        ALUSrc    = 1'b0;
        ExtOp     = 1'b0;
        sc_result = 1'b0;
        case (state_q)
            FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    ir_d    = instr[31:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = dec_halt ? HALTED : EXEC;
            end
            EXEC: begin
                ALUctr = dec_alu;
                ALUSrc = dec_src;
                ExtOp  = dec_ext;
                if (dec_rd || dec_wr) begin
                    state_d = MEM;
                end else if (dec_beq || dec_bne || dec_j || dec_jr) begin
                    state_d = FETCH;
                    PCen    = 1'b1;
                    if (dec_j) begin
                        pc_sel = 2'b10;
                    end else if (dec_jr) begin
                        pc_sel = 2'b11;
                    end else if ((dec_beq && zero) || (dec_bne && !zero)) begin
                        pc_sel = 2'b01;
                    end
                end else begin
                    // JAL, ALU ops, LUI and undefined encodings all finish in WB
                    state_d = WB;
                end
            end
            MEM: begin
                if (dec_rd) begin
                    dREN = 1'b1;
                    if (dhit) begin
                        state_d = WB;
                    end
                end else if (dec_sc) begin
                    // A failing SC never writes and leaves after a single cycle
                    dWEN = sc_ok;
                    if (dhit || !sc_ok) begin
                        state_d = WB;
                    end
                end else begin
                    dWEN = 1'b1;
                    if (dhit) begin
                        state_d = FETCH;
                        PCen    = 1'b1;
                    end
                end
            end
            WB: begin
                RegWr     = !dec_undef;
                PCen      = 1'b1;
                RegDst    = dec_rtype || dec_jal;
                MemtoReg  = dec_rd || dec_sc;
                lui       = dec_lui;
                sc_result = dec_sc && sc_res;
                if (dec_jal) begin
                    pc_sel = 2'b10;
                    jal_s  = 1'b1;
                end
                state_d = FETCH;
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Watchdog: counts consecutive wait cycles; saturates at MEM_TIMEOUT
    always_comb begin
        wd_cnt_d      = '0;
        mem_timeout_d = mem_timeout_q;
        if (MEM_TIMEOUT != 0) begin
            if (((state_q == FETCH) && !ihit) || ((state_q == MEM) && !dhit)) begin
                wd_cnt_d = (wd_cnt_q == MEM_TIMEOUT) ? wd_cnt_q : wd_cnt_q + 32'd1;
            end
            if (wd_cnt_d == MEM_TIMEOUT) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= FETCH;
            ir_q          <= '0;
            wd_cnt_q      <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            wd_cnt_q      <= wd_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign ir          = ir_q;
    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_sync_control_fsm.sv
// tb/tb_sync_control_fsm.sv - scoreboard testbench for sync_control_fsm
module tb_sync_control_fsm;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] instr = '0;
    logic        ihit = 1'b0;
    logic        dhit = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] daddr = 32'h100;
    logic        snoop_inv = 1'b0;
    logic [31:0] ir;
    logic        iREN, dREN, dWEN, PCen, RegWr, ALUSrc, ExtOp, MemtoReg;
    logic        lui, jal_s, halt, mem_timeout, RegDst, sc_result;
    logic [1:0]  pc_sel;
    logic [3:0]  ALUctr;
    logic [2:0]  state;

    sync_control_fsm #(.WORD_W(32), .MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
        .daddr(daddr), .snoop_inv(snoop_inv), .ir(ir), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .PCen(PCen), .RegWr(RegWr), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .MemtoReg(MemtoReg),
        .lui(lui), .jal_s(jal_s), .halt(halt), .mem_timeout(mem_timeout), .RegDst(RegDst),
        .pc_sel(pc_sel), .ALUctr(ALUctr), .state(state), .sc_result(sc_result)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] rel;
        logic [2:0] st;
        logic       pcen;
        logic [1:0] psel;
        logic       regwr;
        logic       m2r;
        logic       rdst;
        logic       lu;
        logic       jal;
        logic       dren;
        logic       dwen;
        logic       scr;
        logic       asrc;
        logic       eop;
        logic [3:0] actr;
        logic       care;
    } ev_t;

    ev_t   sb[$];
    ev_t   mon_a, mon_e;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    string cur_test = "reset";

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Monitor: every EXEC/MEM/WB cycle is a control event matched against the scoreboard
    always @(negedge CLK) begin
        if (nRST && (state == 3'd2 || state == 3'd3 || state == 3'd4)) begin
            mon_a = '0;
            mon_a.rel = 8'(cyc - start_cyc);
            mon_a.st = state;
            mon_a.pcen = PCen;
            mon_a.psel = pc_sel;
            mon_a.regwr = RegWr;
            mon_a.m2r = MemtoReg;
            mon_a.rdst = RegDst;
            mon_a.lu = lui;
            mon_a.jal = jal_s;
            mon_a.dren = dREN;
            mon_a.dwen = dWEN;
            mon_a.scr = sc_result;
            mon_a.asrc = ALUSrc;
            mon_a.eop = ExtOp;
            mon_a.actr = ALUctr;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s unexpected event: got %h expected none", cur_test, mon_a);
            end else begin
                mon_e = sb.pop_front();
                if (!mon_e.care) begin
                    mon_a.actr = mon_e.actr;
                    mon_a.asrc = mon_e.asrc;
                    mon_a.eop = mon_e.eop;
                end
                mon_a.care = mon_e.care;
                chk(cur_test, 64'(mon_a), 64'(mon_e));
            end
        end
    end

    task automatic push_exec(input int rel, input logic care, input logic [3:0] actr,
                             input logic asrc, input logic eop, input logic pcen, input logic [1:0] psel);
        ev_t e = '0;
        e.rel = 8'(rel); e.st = 3'd2; e.care = care; e.actr = actr; e.asrc = asrc; e.eop = eop;
        e.pcen = pcen; e.psel = psel;
        sb.push_back(e);
    endtask

    task automatic push_mem(input int rel, input logic dren, input logic dwen, input logic pcen);
        ev_t e = '0;
        e.rel = 8'(rel); e.st = 3'd3; e.care = 1'b1; e.dren = dren; e.dwen = dwen; e.pcen = pcen;
        sb.push_back(e);
    endtask

    task automatic push_wb(input int rel, input logic regwr, input logic m2r, input logic rdst,
                           input logic lu, input logic jal, input logic [1:0] psel, input logic scr);
        ev_t e = '0;
        e.rel = 8'(rel); e.st = 3'd4; e.care = 1'b1; e.pcen = 1'b1; e.regwr = regwr; e.m2r = m2r;
        e.rdst = rdst; e.lu = lu; e.jal = jal; e.psel = psel; e.scr = scr;
        sb.push_back(e);
    endtask

    // Open-loop driver: ihit in the first cycle, dhit from cycle dhit_at onward
    task automatic run(input string nm, input logic [31:0] w, input int len, input int dhit_at,
                       input logic z, input logic snp);
        cur_test = nm;
        start_cyc = cyc;
        for (int r = 0; r < len; r++) begin
            instr = w;
            ihit = (r == 0);
            dhit = (r >= dhit_at);
            zero = z;
            snoop_inv = snp && (r == 0);
            @(posedge CLK);
            #1;
        end
        ihit = 1'b0;
        dhit = 1'b0;
        snoop_inv = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_outputs", {state, iREN, PCen, RegWr, dREN, dWEN, halt, mem_timeout},
            {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_ir", ir, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        push_exec(2, 1, 4'd2, 0, 0, 0, 2'b00); push_wb(3, 1, 0, 1, 0, 0, 2'b00, 0);
        run("addu", 32'h00221821, 4, 99, 0, 0);
        chk("addu_ir", ir, 32'h00221821);
        push_exec(2, 1, 4'd3, 0, 0, 0, 2'b00); push_wb(3, 1, 0, 1, 0, 0, 2'b00, 0);
        run("subu", 32'h00221823, 4, 99, 0, 0);
        push_exec(2, 1, 4'd5, 1, 0, 0, 2'b00); push_wb(3, 1, 0, 0, 0, 0, 2'b00, 0);
        run("ori", 32'h34220f0f, 4, 99, 0, 0);
        push_exec(2, 0, 4'd0, 0, 0, 0, 2'b00); push_wb(3, 1, 0, 0, 1, 0, 2'b00, 0);
        run("lui", 32'h3c021234, 4, 99, 0, 0);
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00);
        for (int r = 3; r <= 6; r++) push_mem(r, 1, 0, 0);
        push_wb(7, 1, 1, 0, 0, 0, 2'b00, 0);
        run("lw_delay3", 32'h8c220004, 8, 6, 0, 0);
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00); push_mem(3, 0, 1, 1);
        run("sw", 32'hac220004, 4, 3, 0, 0);
        push_exec(2, 1, 4'd3, 0, 1, 1, 2'b01);
        run("beq_taken", 32'h10220003, 3, 99, 1, 0);
        push_exec(2, 1, 4'd3, 0, 1, 1, 2'b00);
        run("beq_not_taken", 32'h10220003, 3, 99, 0, 0);
        push_exec(2, 1, 4'd3, 0, 1, 1, 2'b00);
        run("bne_zero1", 32'h14220003, 3, 99, 1, 0);
        push_exec(2, 1, 4'd3, 0, 1, 1, 2'b01);
        run("bne_zero0", 32'h14220003, 3, 99, 0, 0);
        push_exec(2, 0, 4'd0, 0, 0, 1, 2'b10);
        run("j", 32'h08000010, 3, 99, 0, 0);
        push_exec(2, 0, 4'd0, 0, 0, 1, 2'b11);
        run("jr", 32'h03e00008, 3, 99, 0, 0);
        push_exec(2, 0, 4'd0, 0, 0, 0, 2'b00); push_wb(3, 1, 0, 1, 0, 1, 2'b10, 0);
        run("jal", 32'h0c000010, 4, 99, 0, 0);
        push_exec(2, 0, 4'd0, 0, 0, 0, 2'b00); push_wb(3, 0, 0, 0, 0, 0, 2'b00, 0);
        run("undef_opcode", 32'hf8000000, 4, 99, 0, 0);
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00); push_mem(3, 1, 0, 0); push_wb(4, 1, 1, 0, 0, 0, 2'b00, 0);
        run("ll", 32'hc0220000, 5, 3, 0, 0);
`ifdef LLSC_EN
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00); push_mem(3, 0, 1, 0); push_wb(4, 1, 1, 0, 0, 0, 2'b00, 1);
        run("sc_linked", 32'he0220000, 5, 3, 0, 0);
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00); push_mem(3, 1, 0, 0); push_wb(4, 1, 1, 0, 0, 0, 2'b00, 0);
        run("ll_again", 32'hc0220000, 5, 3, 0, 0);
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00); push_mem(3, 0, 0, 0); push_wb(4, 1, 1, 0, 0, 0, 2'b00, 0);
        run("sc_snooped", 32'he0220000, 5, 3, 0, 1);
`else
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00); push_mem(3, 0, 1, 0); push_mem(4, 0, 1, 0);
        push_wb(5, 1, 1, 0, 0, 0, 2'b00, 1);
        run("sc_plain", 32'he0220000, 6, 4, 0, 0);
`endif
        chk("queue_drained_main", 64'(sb.size()), 64'd0);

        // Reset in the middle of a load that never completes
        push_exec(2, 1, 4'd2, 1, 1, 0, 2'b00); push_mem(3, 1, 0, 0); push_mem(4, 1, 0, 0);
        run("lw_reset_mid_mem", 32'h8c220004, 5, 99, 0, 0);
        nRST = 1'b0;
        #1;
        chk("mid_mem_reset_async", {state, iREN, PCen, RegWr, dREN}, {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        cur_test = "after_reset_idle";
        // Held in FETCH without ihit: watchdog (MEM_TIMEOUT=4) trips after the 4th wait edge
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk("idle_no_pulse", {state, PCen, RegWr}, {3'd0, 1'b0, 1'b0});
            chk($sformatf("timeout_k%0d", k), 64'(mem_timeout), 64'(k >= 5));
        end
        @(posedge CLK);
        #1;
        push_exec(2, 1, 4'd2, 0, 0, 0, 2'b00); push_wb(3, 1, 0, 1, 0, 0, 2'b00, 0);
        run("addu_after_timeout", 32'h00221821, 4, 99, 0, 0);
        chk("timeout_sticky", 64'(mem_timeout), 64'd1);

        // HALT: halted from the third cycle on until reset
        run("halt", 32'hfc000000, 2, 99, 0, 0);
        for (int k = 0; k < 22; k++) begin
            @(negedge CLK);
            chk("halted_hold", {state, halt, iREN, PCen, RegWr, dREN, dWEN}, {3'd5, 1'b1, 5'b0});
        end
        #2;
        nRST = 1'b0;
        #1;
        chk("halt_reset_async", {state, halt, iREN, mem_timeout}, {3'd0, 1'b0, 1'b1, 1'b0});
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #20;
        chk("queue_drained_final", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
